// File: rtl/rvv_backend_dispatch_inflight_tracker_if.sv
// Bundle of dispatch, writeback, retire and predecessor-vector signals for
// the in-flight uop tracker. The master side drives dispatch/wb/retire/flush.
interface rvv_backend_dispatch_inflight_tracker_if #(
  parameter int DEPTH    = 8,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int DISP_NUM = 2,
  parameter int WB_NUM   = 2,
  parameter int RET_NUM  = 2
);
  logic [DISP_NUM-1:0]       disp_valid;
  logic [DISP_NUM-1:0]       disp_w_en;
  logic [DISP_NUM*5-1:0]     disp_w_index;
  logic [DISP_NUM-1:0]       disp_ready;
  logic [DISP_NUM*TAG_W-1:0] disp_tag;

  logic [WB_NUM-1:0]         wb_valid;
  logic [WB_NUM*TAG_W-1:0]   wb_tag;

  logic [RET_NUM-1:0]        retire_valid;
  logic                      flush;

  logic [DEPTH-1:0]          pre_valid;
  logic [DEPTH*5-1:0]        pre_w_index;
  logic [DEPTH-1:0]          pre_w_valid;
  logic [TAG_W:0]            count;
  logic                      full;
  logic                      empty;

  modport master (
    output disp_valid, disp_w_en, disp_w_index, wb_valid, wb_tag,
           retire_valid, flush,
    input  disp_ready, disp_tag, pre_valid, pre_w_index, pre_w_valid,
           count, full, empty
  );

  modport slave (
    input  disp_valid, disp_w_en, disp_w_index, wb_valid, wb_tag,
           retire_valid, flush,
    output disp_ready, disp_tag, pre_valid, pre_w_index, pre_w_valid,
           count, full, empty
  );
endinterface

// File: rtl/rvv_backend_dispatch_inflight_tracker.sv
// In-order circular tracker of dispatched-but-unretired uops; exposes every
// slot as the predecessor vector consumed by the dispatch RAW checker.
module rvv_backend_dispatch_inflight_tracker #(
  parameter int DEPTH    = 8,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int DISP_NUM = 2,
  parameter int WB_NUM   = 2,
  parameter int RET_NUM  = 2
) (
  input logic clk,
  input logic rst_n,
  rvv_backend_dispatch_inflight_tracker_if.slave bus
);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0]   cnt_t;

  logic [DEPTH-1:0] occupied;
  logic [DEPTH-1:0] w_en;
  logic [DEPTH-1:0] w_valid;
  logic [4:0]       w_index [DEPTH];
  tag_t             head;
  tag_t             tail;
  cnt_t             count;

  cnt_t                free_slots;
  logic [DISP_NUM-1:0] ready;
  logic [DISP_NUM-1:0] accept;
  logic [RET_NUM-1:0]  retire;
  logic                ret_err;
  cnt_t                n_acc;
  cnt_t                n_ret;
  tag_t                disp_slot [DISP_NUM];
  tag_t                ret_slot  [RET_NUM];
  tag_t                wb_slot   [WB_NUM];

  // Readiness depends only on registered count, so retire cannot feed dispatch
  // combinationally; the accept chain enforces in-order lane acceptance.
  always_comb begin
    logic chain;
    free_slots = cnt_t'(DEPTH) - count;
    n_acc      = '0;
    chain      = 1'b1;
    for (int i = 0; i < DISP_NUM; i++) begin
      disp_slot[i] = tail + tag_t'(i);
      ready[i]     = free_slots > cnt_t'(i);
      chain        = chain & bus.disp_valid[i] & ready[i];
      accept[i]    = chain;
      n_acc        = n_acc + cnt_t'(chain);
    end
  end

  always_comb begin
    logic rchain;
    n_ret   = '0;
    rchain  = 1'b1;
    ret_err = 1'b0;
    for (int k = 0; k < RET_NUM; k++) begin
      ret_slot[k] = head + tag_t'(k);
      if (rchain && bus.retire_valid[k] && !occupied[ret_slot[k]]) begin
        ret_err = 1'b1;
      end
      rchain    = rchain & bus.retire_valid[k] & occupied[ret_slot[k]];
      retire[k] = rchain;
      n_ret     = n_ret + cnt_t'(rchain);
    end
  end

  always_comb begin
    for (int j = 0; j < WB_NUM; j++) begin
      wb_slot[j] = bus.wb_tag[j*TAG_W +: TAG_W];
    end
  end

  // Update order matters: allocate, then writeback, then retire so that a
  // retire of the same slot wins over a same-cycle writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupied <= '0;
      w_en     <= '0;
      w_valid  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        w_index[e] <= '0;
      end
    end else if (bus.flush) begin
      occupied <= '0;
      w_en     <= '0;
      w_valid  <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        w_index[e] <= '0;
      end
    end else begin
      for (int i = 0; i < DISP_NUM; i++) begin
        if (accept[i]) begin
          occupied[disp_slot[i]] <= 1'b1;
          w_en[disp_slot[i]]     <= bus.disp_w_en[i];
          w_index[disp_slot[i]]  <= bus.disp_w_index[i*5 +: 5];
          w_valid[disp_slot[i]]  <= 1'b0;
        end
      end
      for (int j = 0; j < WB_NUM; j++) begin
        if (bus.wb_valid[j] && occupied[wb_slot[j]]) begin
          w_valid[wb_slot[j]] <= 1'b1;
        end
      end
      for (int k = 0; k < RET_NUM; k++) begin
        if (retire[k]) begin
          occupied[ret_slot[k]] <= 1'b0;
          w_en[ret_slot[k]]     <= 1'b0;
          w_valid[ret_slot[k]]  <= 1'b0;
        end
      end
      head  <= head + tag_t'(n_ret);
      tail  <= tail + tag_t'(n_acc);
      count <= count + n_acc - n_ret;
    end
  end

  assign bus.disp_ready  = ready;
  assign bus.pre_valid   = occupied & w_en;
  assign bus.pre_w_valid = occupied & w_valid;
  assign bus.count       = count;
  assign bus.full        = (count == cnt_t'(DEPTH));
  assign bus.empty       = (count == '0);

  always_comb begin
    bus.disp_tag    = '0;
    bus.pre_w_index = '0;
    for (int i = 0; i < DISP_NUM; i++) begin
      bus.disp_tag[i*TAG_W +: TAG_W] = disp_slot[i];
    end
    for (int e = 0; e < DEPTH; e++) begin
      bus.pre_w_index[e*5 +: 5] = w_index[e];
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      assert (tag_t'(tail - head) == count[TAG_W-1:0] && count <= cnt_t'(DEPTH));
      assert (!((|accept) && count == cnt_t'(DEPTH)));
      assert (bus.flush || !ret_err);
      assert (!$isunknown({bus.pre_valid, bus.pre_w_index, bus.pre_w_valid,
                           bus.count, bus.full, bus.empty, bus.disp_ready,
                           bus.disp_tag}));
    end
  end
`endif

endmodule

// File: tb/tb_rvv_backend_dispatch_inflight_tracker.sv
// Directed + randomized bench for the in-flight tracker, checked against an
// ordered-queue reference model of outstanding uops.
module tb_rvv_backend_dispatch_inflight_tracker;
  localparam int DEPTH    = 8;
  localparam int TAG_W    = 3;
  localparam int DISP_NUM = 2;
  localparam int WB_NUM   = 2;
  localparam int RET_NUM  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rvv_backend_dispatch_inflight_tracker_if #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DISP_NUM(DISP_NUM), .WB_NUM(WB_NUM), .RET_NUM(RET_NUM)
  ) bus ();

  rvv_backend_dispatch_inflight_tracker #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DISP_NUM(DISP_NUM), .WB_NUM(WB_NUM), .RET_NUM(RET_NUM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int tag;
    bit w_en;
    bit wv;
  } ent_t;

  ent_t q[$];          // outstanding uops, oldest first
  int   head_tag;
  int   idx_mem[DEPTH]; // last destination index written into each slot
  int   n_assert = 0;
  int   n_fail = 0;

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    head_tag = 0;
    for (int t = 0; t < DEPTH; t++) idx_mem[t] = 0;
  endtask

  task automatic model_edge();
    int sz, nacc, nret;
    sz = q.size();
    nacc = 0;
    nret = 0;
    if (bus.flush) begin
      model_clear();
      return;
    end
    for (int i = 0; i < DISP_NUM; i++)
      if (bus.disp_valid[i] && (DEPTH - sz) > i && nacc == i) nacc++;
    for (int j = 0; j < WB_NUM; j++) begin
      if (bus.wb_valid[j]) begin
        int p;
        p = (int'(bus.wb_tag[j*TAG_W +: TAG_W]) - head_tag + DEPTH) % DEPTH;
        if (p < sz) q[p].wv = 1'b1;
      end
    end
    for (int k = 0; k < RET_NUM; k++)
      if (bus.retire_valid[k] && nret == k && k < sz) nret++;
    for (int i = 0; i < nacc; i++) begin
      ent_t e;
      e.tag  = (head_tag + sz + i) % DEPTH;
      e.w_en = bus.disp_w_en[i];
      e.wv   = 1'b0;
      idx_mem[e.tag] = int'(bus.disp_w_index[i*5 +: 5]);
      q.push_back(e);
    end
    repeat (nret) void'(q.pop_front());
    head_tag = (head_tag + nret) % DEPTH;
  endtask

  task automatic check_model(string name);
    logic [DEPTH-1:0]          ev, ewv;
    logic [DEPTH*5-1:0]        eidx;
    logic [DISP_NUM-1:0]       erdy;
    logic [DISP_NUM*TAG_W-1:0] etag;
    ev = '0;
    ewv = '0;
    eidx = '0;
    for (int n = 0; n < q.size(); n++) begin
      ev[q[n].tag]  = q[n].w_en;
      ewv[q[n].tag] = q[n].wv;
    end
    for (int t = 0; t < DEPTH; t++) eidx[t*5 +: 5] = 5'(idx_mem[t]);
    for (int i = 0; i < DISP_NUM; i++) begin
      erdy[i] = (DEPTH - q.size()) > i;
      etag[i*TAG_W +: TAG_W] = TAG_W'((head_tag + q.size() + i) % DEPTH);
    end
    chk({name, "/pre_valid"},   bus.pre_valid, ev);
    chk({name, "/pre_w_valid"}, bus.pre_w_valid, ewv);
    chk({name, "/pre_w_index"}, bus.pre_w_index, eidx);
    chk({name, "/count"},       bus.count, q.size());
    chk({name, "/full"},        bus.full, q.size() == DEPTH);
    chk({name, "/empty"},       bus.empty, q.size() == 0);
    chk({name, "/disp_ready"},  bus.disp_ready, erdy);
    chk({name, "/disp_tag"},    bus.disp_tag, etag);
  endtask

  task automatic idle();
    bus.disp_valid   = '0;
    bus.disp_w_en    = '0;
    bus.disp_w_index = '0;
    bus.wb_valid     = '0;
    bus.wb_tag       = '0;
    bus.retire_valid = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic step(string name);
    @(posedge clk);
    model_edge();
    #1;
    check_model(name);
  endtask

  task automatic dispatch2(logic [1:0] en, int i0, int i1);
    bus.disp_valid   = 2'b11;
    bus.disp_w_en    = en;
    bus.disp_w_index = {5'(i1), 5'(i0)};
  endtask

  initial begin
    int sz;
    model_clear();
    idle();

    // Reset state
    #12;
    chk("rst/pre_valid", bus.pre_valid, 0);
    chk("rst/pre_w_valid", bus.pre_w_valid, 0);
    chk("rst/pre_w_index", bus.pre_w_index, 0);
    chk("rst/count", bus.count, 0);
    chk("rst/empty", bus.empty, 1);
    chk("rst/full", bus.full, 0);
    chk("rst/disp_ready", bus.disp_ready, 2'b11);
    rst_n = 1'b1;

    // First dispatch pair
    dispatch2(2'b01, 5, 7);
    #1;
    chk("first/disp_tag", bus.disp_tag, 6'b001_000);
    step("first");
    chk("first/pre_valid_c", bus.pre_valid, 8'h01);
    chk("first/idx0_c", bus.pre_w_index[4:0], 5);
    chk("first/count_c", bus.count, 2);

    // Fill to DEPTH
    for (int c = 0; c < 3; c++) begin
      dispatch2(2'($urandom), $urandom_range(0, 31), $urandom_range(0, 31));
      step("fill");
    end
    chk("fill/full_c", bus.full, 1);
    chk("fill/ready_c", bus.disp_ready, 2'b00);
    dispatch2(2'b11, 9, 10);
    bus.retire_valid = 2'b11;
    step("full_ret");
    chk("full_ret/count_c", bus.count, 6);
    chk("full_ret/ready_c", bus.disp_ready, 2'b11);
    idle();

    // Writeback to occupied tag 3 and unoccupied tag 0
    bus.wb_valid = 2'b11;
    bus.wb_tag   = {3'd0, 3'd3};
    step("wb3");
    chk("wb3/pre_w_valid_c", bus.pre_w_valid, 8'h08);
    idle();

    // Writeback and retire of the head together
    bus.wb_valid     = 2'b01;
    bus.wb_tag       = {3'd0, 3'd2};
    bus.retire_valid = 2'b01;
    step("wb_ret");
    chk("wb_ret/pre_w_valid_c", bus.pre_w_valid, 8'h08);
    chk("wb_ret/count_c", bus.count, 5);
    idle();

    // Gapped retire and gapped dispatch do nothing
    bus.retire_valid = 2'b10;
    step("ret_gap");
    chk("ret_gap/count_c", bus.count, 5);
    idle();
    bus.disp_valid = 2'b10;
    step("disp_gap");
    chk("disp_gap/count_c", bus.count, 5);
    chk("disp_gap/tag_c", bus.disp_tag, 6'b001_000);
    idle();

    // Flush overrides a same-cycle dispatch
    dispatch2(2'b11, 3, 4);
    bus.flush = 1'b1;
    step("flush");
    chk("flush/count_c", bus.count, 0);
    chk("flush/empty_c", bus.empty, 1);
    chk("flush/pre_valid_c", bus.pre_valid, 0);
    chk("flush/pre_w_valid_c", bus.pre_w_valid, 0);
    chk("flush/pre_w_index_c", bus.pre_w_index, 0);
    idle();

    // Writeback to an unoccupied slot is ignored
    dispatch2(2'b11, 11, 12);
    step("pair");
    idle();
    bus.wb_valid = 2'b01;
    bus.wb_tag   = {3'd0, 3'd6};
    step("wb6");
    chk("wb6/pre_w_valid_c", bus.pre_w_valid, 0);
    idle();

    // Steady-state wrap-around: 2 in, 2 out per cycle
    for (int c = 0; c < 20; c++) begin
      dispatch2(2'b11, (2 * c) % 32, (2 * c + 1) % 32);
      bus.retire_valid = 2'b11;
      #1;
      if (c == 2) chk("wrap/tag67", bus.disp_tag, {3'd7, 3'd6});
      if (c == 3) chk("wrap/tag01", bus.disp_tag, {3'd1, 3'd0});
      step("wrap");
    end
    idle();

    // Randomized traffic
    for (int c = 0; c < 300; c++) begin
      int r;
      sz = q.size();
      bus.disp_valid   = 2'($urandom);
      bus.disp_w_en    = 2'($urandom);
      bus.disp_w_index = 10'($urandom);
      bus.wb_valid     = 2'($urandom);
      bus.wb_tag       = 6'($urandom);
      r = $urandom_range(0, 3);
      case (r)
        0:       bus.retire_valid = 2'b00;
        1:       bus.retire_valid = (sz >= 1) ? 2'b01 : 2'b00;
        2:       bus.retire_valid = (sz >= 2) ? 2'b11 : 2'b00;
        default: bus.retire_valid = 2'b10;
      endcase
      bus.flush = ($urandom_range(0, 31) == 0);
      step("rand");
    end
    idle();

    // Asynchronous reset mid-run clears outputs without a clock edge
    dispatch2(2'b11, 21, 22);
    step("pre_arst");
    idle();
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("arst/count", bus.count, 0);
    chk("arst/empty", bus.empty, 1);
    chk("arst/pre_valid", bus.pre_valid, 0);
    chk("arst/pre_w_index", bus.pre_w_index, 0);
    chk("arst/disp_ready", bus.disp_ready, 2'b11);
    check_model("arst");
    #1;
    rst_n = 1'b1;
    dispatch2(2'b10, 1, 2);
    step("post_arst");
    idle();
    step("post_arst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
